dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- One-way (direct-mapped), write-back, write-allocate data-cache controller.
- Sits at the memory end of the EX/MEM pipeline register. It takes the registered ALU result as the address, rt data as the store data, and MemRead/MemWrite as the request. It returns load data and a stall to the pipeline.
- Refills and evicts whole lines over a handshake to an off-chip data memory with multi-cycle latency.

Parameters:
- LINE_BITS, 256, cache line width in bits (8 words, 32 bytes).
- NUM_LINES, 32, number of lines. Must be a power of 2.
- IDX_W, 5, log2(NUM_LINES).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous reset, active low.
- cpu_addr_i  in  32  byte address (EX/MEM result).
- cpu_data_i  in  32  store data (EX/MEM rt data).
- cpu_memread_i  in  1  load request.
- cpu_memwrite_i  in  1  store request.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  stalls the pipeline while high.
- mem_addr_o  out  32  line-aligned memory address.
- mem_data_o  out  LINE_BITS  eviction data.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_data_i  in  LINE_BITS  refill data.
- mem_ack_i  in  1  one-cycle pulse: request complete.

Behaviour:
- Address split:
  - offset = addr[4:0]; word select = addr[4:2]; addr[1:0] ignored.
  - index = addr[5+IDX_W-1:5].
  - tag = addr[31:5+IDX_W] (22 bits at defaults).
- Per-line storage: valid, dirty, tag, data.
- req = cpu_memread_i | cpu_memwrite_i. If both are high, the request is treated as a write.
- hit = valid[index] & (tag_store[index] == tag). Combinational.
- cpu_stall_o = (req & ~hit) | (state != IDLE). Combinational.
- cpu_data_o = selected word of the indexed line when cpu_memread_i & hit; otherwise 0.
- Write hit (state IDLE): on posedge, the selected word is replaced with cpu_data_i and dirty[index] is set to 1. Zero added latency.
- Read hit: zero added latency; no state change.
- FSM states: IDLE, MISS, WRITEBACK, ALLOCATE, REFILL.
  - IDLE: req & ~hit -> MISS. Otherwise stay.
  - MISS: one cycle, no memory request. If valid & dirty -> WRITEBACK, else -> ALLOCATE.
  - WRITEBACK:
    - mem_enable_o=1, mem_write_o=1.
    - mem_addr_o = {stored tag, index, 5'b0}; mem_data_o = stored line.
    - Holds until mem_ack_i, then -> ALLOCATE. dirty[index] is cleared on that ack.
  - ALLOCATE:
    - mem_enable_o=1, mem_write_o=0.
    - mem_addr_o = {tag, index, 5'b0}.
    - On mem_ack_i: line is loaded from mem_data_i, tag is written, valid=1, dirty=0; -> REFILL.
  - REFILL: one cycle; -> IDLE. The request then resolves as a hit in IDLE (a store sets dirty at that point).
- Memory outputs are decoded from state (Moore). In IDLE and MISS: mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
- mem_ack_i is ignored outside WRITEBACK and ALLOCATE.
- Address and data inputs are held stable by the stalled pipeline for the whole miss; the controller does not latch them.
- A request dropping mid-miss (not expected) does not abort the sequence; the refill completes.
- Reset (async, rst_i=0):
  - state=IDLE; all valid=0, all dirty=0.
  - mem_enable_o=0 and mem_write_o=0 immediately.
  - cpu_stall_o = req (every access misses after reset).
  - Tag and data arrays need not be cleared.
- Reset mid-WRITEBACK/ALLOCATE: the request is abandoned and a later ack is ignored.
- Index wrap-around: addresses differing only in tag map to the same line and evict each other.

Test Plan:
- Cold load: reset, then read 0x0000_0040 with memory line = {8 words 0x1000..0x1007}. Required: stall rises same cycle; no WRITEBACK; ALLOCATE addr 0x40; after ack, REFILL, then cpu_data_o=0x1000 and stall low.
- Hit latency: repeat read of 0x0000_0044. Required: stall=0, cpu_data_o=0x1001 in the same cycle; mem_enable_o stays 0.
- Store hit then conflict evict:
  - Write 0xDEADBEEF to 0x40 (hit): stall stays 0 and dirty is set.
  - Then read 0x0000_0440 (same index, new tag). Required: WRITEBACK to 0x40 with word0=0xDEADBEEF, then ALLOCATE 0x440.
- Write miss allocate: write 0x12345678 to 0x0000_0808 (invalid line). Required: ALLOCATE 0x800; after REFILL, word2=0x12345678 and the line is dirty.
- Memory latency: ack delayed 10 cycles in both WRITEBACK and ALLOCATE. Required: enable and addr stable all 10 cycles; stall continuous; exactly one eviction and one refill.
- Reset mid-ALLOCATE: assert rst_i=0 at cycle 3 of a refill. Required: mem_enable_o drops asynchronously; state IDLE; a stray ack afterwards causes no update; the next read misses again.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Serves loads and stores from the EX/MEM stage with zero added latency on a hit.
// A miss stalls the pipeline while the line is evicted (if dirty) and refilled
// over a request/ack handshake to an off-chip data memory.
// The address and store data are held by the stalled pipeline for the whole
// miss, so nothing is latched here.

module dcache_ctrl #(
    parameter int LINE_BITS = 256,
    parameter int NUM_LINES = 32,
    parameter int IDX_W     = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_memread_i,
    input  logic                 cpu_memwrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int OFF_W = 5;
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        MISS,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    state_t state;
    state_t next_state;

    // Per-line bookkeeping; only valid and dirty need a reset value.
    logic [NUM_LINES-1:0] valid;
    logic [NUM_LINES-1:0] dirty;
    logic [TAG_W-1:0]     tag_store  [NUM_LINES];
    logic [LINE_BITS-1:0] data_store [NUM_LINES];

    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic [2:0]       word_sel;
    logic [7:0]       word_base;
    logic             req;
    logic             hit;
    logic             write_hit;
    logic             wb_done;
    logic             refill_done;
    logic             unused_addr_bits;

    assign index     = cpu_addr_i[OFF_W +: IDX_W];
    assign tag       = cpu_addr_i[31 -: TAG_W];
    assign word_sel  = cpu_addr_i[4:2];
    assign word_base = {word_sel, 5'b0};

    // Byte-within-word bits play no part in a word-wide cache.
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign req = cpu_memread_i | cpu_memwrite_i;
    assign hit = valid[index] && (tag_store[index] == tag);

    // A store hit lands only in IDLE; in REFILL the line already matches, but
    // the store is deliberately deferred one cycle until the FSM is back in IDLE.
    assign write_hit   = (state == IDLE) && cpu_memwrite_i && hit;
    assign wb_done     = (state == WRITEBACK) && mem_ack_i;
    assign refill_done = (state == ALLOCATE) && mem_ack_i;

    assign cpu_stall_o = (req && !hit) || (state != IDLE);
    assign cpu_data_o  = (cpu_memread_i && hit) ? data_store[index][word_base +: 32] : 32'h0;

    // State register; reset returns to IDLE, which abandons any memory request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Valid/dirty flags: refill installs a clean line, eviction cleans, store hit dirties.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (refill_done) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (wb_done) begin
            dirty[index] <= 1'b0;
        end else if (write_hit) begin
            dirty[index] <= 1'b1;
        end
    end

    // Tag and data arrays: loaded on refill, one word patched on a store hit.
    always_ff @(posedge clk_i) begin
        if (refill_done) begin
            data_store[index] <= mem_data_i;
            tag_store[index]  <= tag;
        end else if (write_hit) begin
            data_store[index][word_base +: 32] <= cpu_data_i;
        end
    end

    // Next-state logic and Moore decode of the memory-side outputs.
    always_comb begin
        next_state   = state;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0;
        mem_data_o   = '0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    next_state = MISS;
                end
            end
            MISS: begin
                if (valid[index] && dirty[index]) begin
                    next_state = WRITEBACK;
                end else begin
                    next_state = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_store[index], index, 5'b0};
                mem_data_o   = data_store[index];
                if (mem_ack_i) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, index, 5'b0};
                if (mem_ack_i) begin
                    next_state = REFILL;
                end
            end
            REFILL: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench for dcache_ctrl with a transaction-level cache
// model, a latency-programmable memory responder and a per-cycle compare.

module tb_dcache_ctrl;

    localparam int LINE_BITS = 256;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [31:0]          cpu_addr_i;
    logic [31:0]          cpu_data_i;
    logic                 cpu_memread_i;
    logic                 cpu_memwrite_i;
    logic [31:0]          cpu_data_o;
    logic                 cpu_stall_o;
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [LINE_BITS-1:0] mem_data_i;
    logic                 mem_ack_i;

    int checks = 0;
    int errors = 0;

    dcache_ctrl #(
        .LINE_BITS(256),
        .NUM_LINES(32),
        .IDX_W(5)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i),
        .cpu_memread_i(cpu_memread_i),
        .cpu_memwrite_i(cpu_memwrite_i),
        .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // Shared comparison helper
    task automatic check_output(input string name, input logic [255:0] actual,
                                input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic record_fail(input string name, input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: %s", name, what);
    endtask

    // Backing memory: untouched lines hold a pattern derived from the line address
    logic [LINE_BITS-1:0] mem_model [logic [26:0]];

    function automatic logic [255:0] default_line(input logic [26:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = 32'hA000_0000 | (32'(la) << 4) | 32'(w);
        end
        return l;
    endfunction

    function automatic logic [255:0] mem_fetch(input logic [26:0] la);
        if (mem_model.exists(la)) begin
            return mem_model[la];
        end
        return default_line(la);
    endfunction

    // Memory responder: acks each request after ack_delay extra cycles
    int                   ack_delay = 2;
    bit                   resp_en   = 1'b1;
    int                   resp_cnt  = 0;
    int                   wb_count  = 0;
    int                   alloc_count = 0;
    logic [31:0]          wb_addr   = 32'h0;
    logic [31:0]          alloc_addr = 32'h0;
    logic [LINE_BITS-1:0] wb_line   = '0;

    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (resp_en) begin
                mem_ack_i = 1'b0;
            end
            if (resp_en && rst_i && mem_enable_o) begin
                if (resp_cnt >= ack_delay) begin
                    mem_ack_i = 1'b1;
                    resp_cnt  = 0;
                    if (mem_write_o) begin
                        mem_model[mem_addr_o[31:5]] = mem_data_o;
                        wb_count++;
                        wb_addr = mem_addr_o;
                        wb_line = mem_data_o;
                    end else begin
                        mem_data_i = mem_fetch(mem_addr_o[31:5]);
                        alloc_count++;
                        alloc_addr = mem_addr_o;
                    end
                end else begin
                    resp_cnt++;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // Cycle counters used by the latency scenario
    int wb_cycles = 0;
    int al_cycles = 0;
    int stall_cycles = 0;

    always @(negedge clk_i) begin
        if (mem_enable_o && mem_write_o) wb_cycles++;
        if (mem_enable_o && !mem_write_o) al_cycles++;
        if (cpu_stall_o) stall_cycles++;
    end

    task automatic clear_counters();
        wb_cycles    = 0;
        al_cycles    = 0;
        stall_cycles = 0;
        wb_count     = 0;
        alloc_count  = 0;
    endtask

    // Cache model: line contents plus a queue of pending miss operations
    typedef enum int {OP_MISS, OP_WR, OP_RD, OP_REFILL} op_kind_t;
    typedef struct {
        op_kind_t             kind;
        logic [31:0]          addr;
        logic [LINE_BITS-1:0] data;
    } op_t;

    logic                 m_valid [32];
    logic                 m_dirty [32];
    logic [21:0]          m_tag   [32];
    logic [LINE_BITS-1:0] m_line  [32];
    op_t                  ops[$];

    function automatic logic m_hit(input logic [31:0] addr);
        return m_valid[addr[9:5]] && (m_tag[addr[9:5]] == addr[31:10]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        ops.delete();
    endtask

    task automatic model_step();
        logic [4:0]  idx;
        logic [21:0] tg;
        logic        req;
        idx = cpu_addr_i[9:5];
        tg  = cpu_addr_i[31:10];
        req = cpu_memread_i | cpu_memwrite_i;
        if (ops.size() == 0) begin
            if (req && !m_hit(cpu_addr_i)) begin
                ops.push_back('{kind: OP_MISS, addr: 32'h0, data: '0});
                if (m_valid[idx] && m_dirty[idx]) begin
                    ops.push_back('{kind: OP_WR, addr: {m_tag[idx], idx, 5'b0}, data: m_line[idx]});
                end
                ops.push_back('{kind: OP_RD, addr: {tg, idx, 5'b0}, data: '0});
                ops.push_back('{kind: OP_REFILL, addr: 32'h0, data: '0});
            end else if (cpu_memwrite_i) begin
                m_line[idx][{cpu_addr_i[4:2], 5'b0} +: 32] = cpu_data_i;
                m_dirty[idx] = 1'b1;
            end
        end else begin
            case (ops[0].kind)
                OP_WR: begin
                    if (mem_ack_i) begin
                        m_dirty[ops[0].addr[9:5]] = 1'b0;
                        void'(ops.pop_front());
                    end
                end
                OP_RD: begin
                    if (mem_ack_i) begin
                        m_line[idx]  = mem_data_i;
                        m_tag[idx]   = tg;
                        m_valid[idx] = 1'b1;
                        m_dirty[idx] = 1'b0;
                        void'(ops.pop_front());
                    end
                end
                default: void'(ops.pop_front());
            endcase
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rst_i);
            if (!rst_i) begin
                model_reset();
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle compare of every DUT output against the model
    initial begin
        logic [31:0] exp_data;
        logic        req;
        forever begin
            @(negedge clk_i);
            req = cpu_memread_i | cpu_memwrite_i;
            exp_data = (cpu_memread_i && m_hit(cpu_addr_i)) ?
                       m_line[cpu_addr_i[9:5]][{cpu_addr_i[4:2], 5'b0} +: 32] : 32'h0;
            check_output("cpu_data_o", cpu_data_o, exp_data);
            if (ops.size() == 0) begin
                check_output("cpu_stall_o", cpu_stall_o, req && !m_hit(cpu_addr_i));
                check_output("mem_enable_o", mem_enable_o, 0);
                check_output("mem_write_o", mem_write_o, 0);
                check_output("mem_addr_o", mem_addr_o, 0);
                check_output("mem_data_o", mem_data_o, 0);
            end else begin
                check_output("cpu_stall_o", cpu_stall_o, 1);
                case (ops[0].kind)
                    OP_MISS: begin
                        check_output("miss_mem_enable_o", mem_enable_o, 0);
                        check_output("miss_mem_write_o", mem_write_o, 0);
                        check_output("miss_mem_addr_o", mem_addr_o, 0);
                        check_output("miss_mem_data_o", mem_data_o, 0);
                    end
                    OP_WR: begin
                        check_output("wb_mem_enable_o", mem_enable_o, 1);
                        check_output("wb_mem_write_o", mem_write_o, 1);
                        check_output("wb_mem_addr_o", mem_addr_o, ops[0].addr);
                        check_output("wb_mem_data_o", mem_data_o, ops[0].data);
                    end
                    OP_RD: begin
                        check_output("alloc_mem_enable_o", mem_enable_o, 1);
                        check_output("alloc_mem_write_o", mem_write_o, 0);
                        check_output("alloc_mem_addr_o", mem_addr_o, ops[0].addr);
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic apply_stimulus(input logic rd, input logic wr,
                                  input logic [31:0] addr, input logic [31:0] data);
        cpu_memread_i  = rd;
        cpu_memwrite_i = wr;
        cpu_addr_i     = addr;
        cpu_data_i     = data;
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Called at a negedge; returns at the first negedge with stall low
    task automatic wait_unstall(input string name, input int max_cycles);
        int n;
        n = 0;
        while (cpu_stall_o && n < max_cycles) begin
            @(negedge clk_i);
            n++;
        end
        if (cpu_stall_o) begin
            record_fail(name, $sformatf("stall still 1 after %0d cycles, expected 0", max_cycles));
        end
    endtask

    initial begin
        logic [LINE_BITS-1:0] l40;
        int n;
        for (int w = 0; w < 8; w++) begin
            l40[w*32 +: 32] = 32'h1000 + 32'(w);
        end
        mem_model[27'd2] = l40;
        rst_i = 1'b0;
        apply_stimulus(0, 0, 32'h0, 32'h0);

        // Cold load of 0x40 (request raised while still in reset)
        next_cycle();
        next_cycle();
        apply_stimulus(1, 0, 32'h0000_0040, 32'h0);
        @(negedge clk_i);
        check_output("reset_stall", cpu_stall_o, 1);
        check_output("reset_mem_enable", mem_enable_o, 0);
        next_cycle();
        rst_i = 1'b1;
        clear_counters();
        @(negedge clk_i);
        check_output("cold_stall_same_cycle", cpu_stall_o, 1);
        wait_unstall("cold_load", 60);
        check_output("cold_no_writeback", wb_count, 0);
        check_output("cold_alloc_count", alloc_count, 1);
        check_output("cold_alloc_addr", alloc_addr, 32'h40);
        check_output("cold_data", cpu_data_o, 32'h1000);

        // Hit latency
        next_cycle();
        apply_stimulus(1, 0, 32'h0000_0044, 32'h0);
        @(negedge clk_i);
        check_output("hit_stall", cpu_stall_o, 0);
        check_output("hit_data", cpu_data_o, 32'h1001);
        check_output("hit_mem_enable", mem_enable_o, 0);

        // Store hit, then conflict eviction
        next_cycle();
        apply_stimulus(0, 1, 32'h0000_0040, 32'hDEAD_BEEF);
        @(negedge clk_i);
        check_output("store_hit_stall", cpu_stall_o, 0);
        next_cycle();
        clear_counters();
        apply_stimulus(1, 0, 32'h0000_0440, 32'h0);
        @(negedge clk_i);
        wait_unstall("conflict", 60);
        check_output("conflict_wb_count", wb_count, 1);
        check_output("conflict_wb_addr", wb_addr, 32'h40);
        check_output("conflict_wb_word0", wb_line[31:0], 32'hDEAD_BEEF);
        check_output("conflict_wb_word1", wb_line[63:32], 32'h1001);
        check_output("conflict_alloc_addr", alloc_addr, 32'h440);
        check_output("conflict_data", cpu_data_o, 32'hA000_0220);

        // Write-miss allocate
        next_cycle();
        clear_counters();
        apply_stimulus(0, 1, 32'h0000_0808, 32'h1234_5678);
        @(negedge clk_i);
        wait_unstall("write_miss", 60);
        check_output("write_miss_wb_count", wb_count, 0);
        check_output("write_miss_alloc_addr", alloc_addr, 32'h800);
        next_cycle();
        apply_stimulus(1, 0, 32'h0000_0808, 32'h0);
        @(negedge clk_i);
        check_output("write_miss_word2", cpu_data_o, 32'h1234_5678);
        next_cycle();
        clear_counters();
        apply_stimulus(1, 0, 32'h0000_0008, 32'h0);
        @(negedge clk_i);
        wait_unstall("write_miss_evict", 60);
        check_output("write_miss_dirty_wb", wb_count, 1);
        check_output("write_miss_wb_addr", wb_addr, 32'h800);
        check_output("write_miss_wb_word2", wb_line[95:64], 32'h1234_5678);
        check_output("write_miss_wb_word0", wb_line[31:0], 32'hA000_0400);
        check_output("evict_read_data", cpu_data_o, 32'hA000_0002);

        // Long memory latency on both eviction and refill
        next_cycle();
        apply_stimulus(0, 1, 32'h0000_0000, 32'h0000_0055);
        @(negedge clk_i);
        check_output("latency_store_hit", cpu_stall_o, 0);
        next_cycle();
        ack_delay = 10;
        clear_counters();
        apply_stimulus(1, 0, 32'h0000_0400, 32'h0);
        @(negedge clk_i);
        wait_unstall("latency", 100);
        check_output("latency_wb_count", wb_count, 1);
        check_output("latency_alloc_count", alloc_count, 1);
        check_output("latency_wb_cycles", wb_cycles, 11);
        check_output("latency_alloc_cycles", al_cycles, 11);
        check_output("latency_stall_cycles", stall_cycles, 25);
        check_output("latency_wb_word0", wb_line[31:0], 32'h55);
        check_output("latency_data", cpu_data_o, 32'hA000_0200);

        // Reset in the third ALLOCATE cycle
        next_cycle();
        clear_counters();
        apply_stimulus(1, 0, 32'h0000_0C40, 32'h0);
        @(negedge clk_i);
        n = 0;
        while (!mem_enable_o && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        if (!mem_enable_o) begin
            record_fail("reset_mid_alloc_start", "mem_enable_o never rose, expected 1");
        end
        check_output("reset_mid_alloc_write", mem_write_o, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check_output("reset_async_enable", mem_enable_o, 0);
        check_output("reset_async_write", mem_write_o, 0);
        check_output("reset_async_stall", cpu_stall_o, 1);
        next_cycle();
        apply_stimulus(0, 0, 32'h0, 32'h0);
        next_cycle();
        rst_i = 1'b1;
        resp_en = 1'b0;
        next_cycle();
        mem_data_i = '1;
        mem_ack_i  = 1'b1;
        next_cycle();
        mem_ack_i = 1'b0;
        resp_en   = 1'b1;
        ack_delay = 1;
        @(negedge clk_i);
        check_output("stray_ack_stall", cpu_stall_o, 0);
        check_output("stray_ack_enable", mem_enable_o, 0);
        next_cycle();
        clear_counters();
        apply_stimulus(1, 0, 32'h0000_0040, 32'h0);
        @(negedge clk_i);
        check_output("miss_after_reset", cpu_stall_o, 1);
        wait_unstall("after_reset", 60);
        check_output("after_reset_alloc_addr", alloc_addr, 32'h40);
        check_output("after_reset_data", cpu_data_o, 32'hDEAD_BEEF);

        // Read and write together behave as a store
        next_cycle();
        apply_stimulus(1, 1, 32'h0000_0044, 32'h0000_0077);
        @(negedge clk_i);
        check_output("rdwr_stall", cpu_stall_o, 0);
        check_output("rdwr_data", cpu_data_o, 32'h1001);
        next_cycle();
        apply_stimulus(1, 0, 32'h0000_0044, 32'h0);
        @(negedge clk_i);
        check_output("rdwr_stored", cpu_data_o, 32'h77);

        next_cycle();
        apply_stimulus(0, 0, 32'h0, 32'h0);
        next_cycle();
        next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
